// File: rtl/cmos_dvp_capture_if.sv
// DVP sensor bus plus the framed pixel stream and geometry reports of the capture stage.
// de_o is a valid-only strobe with no ready: the consumer must take the pixel in the cycle de_o is high.
interface cmos_dvp_capture_if;
   logic        cmos_vsync;
   logic        cmos_href;
   logic [7:0]  cmos_data;
   logic [15:0] pdata_o;
   logic        de_o;
   logic        vs_o;
   logic [15:0] frame_cnt_o;
   logic [11:0] h_meas_o;
   logic [11:0] v_meas_o;
   logic        size_err_o;
   logic [1:0]  dbg_state;

   modport master (
      output cmos_vsync, cmos_href, cmos_data,
      input  pdata_o, de_o, vs_o, frame_cnt_o, h_meas_o, v_meas_o, size_err_o, dbg_state
   );

   modport slave (
      input  cmos_vsync, cmos_href, cmos_data,
      output pdata_o, de_o, vs_o, frame_cnt_o, h_meas_o, v_meas_o, size_err_o, dbg_state
   );
endinterface

// File: rtl/cmos_dvp_capture.sv
// DVP capture: registers the sensor bus, drops the settling frames, pairs bytes into RGB565
// pixels and measures line/frame geometry.
module cmos_dvp_capture #(
   parameter int          SKIP_FRAMES = 10,
   parameter bit          BYTE_ORDER  = 1'b0,
   parameter bit          VS_POL      = 1'b1,
   parameter logic [11:0] H_EXP       = 12'd1280,
   parameter logic [11:0] V_EXP       = 12'd720
) (
   input logic               pixel_clk,
   input logic               rst_n,
   cmos_dvp_capture_if.slave dvp
);
   typedef enum logic [1:0] {IDLE = 2'd0, SKIP = 2'd1, RUN = 2'd2} state_t;

   localparam logic [15:0] SKIP_N = 16'(SKIP_FRAMES);
   localparam logic [11:0] CNT_MAX = 12'hFFF;

   state_t      state, state_nxt;
   logic [15:0] skip_cnt, skip_nxt;

   logic        vs_n_r, vs_n_d, href_r, href_d;
   logic [7:0]  data_r, byte_hold;
   logic        phase;
   logic [11:0] h_cnt, v_cnt, v_cnt_le, h_meas, v_meas;
   logic        err_acc, fs_seen, size_err;
   logic [15:0] pdata, frame_cnt;
   logic        de, vs_out;
   logic        fs, le, byte_en, pix, run_nxt, line_bad;

   // vsync is normalized before registering so reset leaves it inactive for either polarity
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_n_r <= 1'b0;
         vs_n_d <= 1'b0;
         href_r <= 1'b0;
         href_d <= 1'b0;
         data_r <= 8'd0;
      end else begin
         vs_n_r <= dvp.cmos_vsync ^ ~VS_POL;
         vs_n_d <= vs_n_r;
         href_r <= dvp.cmos_href;
         href_d <= href_r;
         data_r <= dvp.cmos_data;
      end
   end

   assign fs      = vs_n_r & ~vs_n_d;
   assign le      = href_d & ~href_r;
   assign byte_en = href_r & ~vs_n_r;
   assign pix     = byte_en & phase;

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         skip_cnt <= 16'd0;
      end else begin
         state    <= state_nxt;
         skip_cnt <= skip_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      skip_nxt  = skip_cnt;
      case (state)
         IDLE: if (fs) begin
            if (SKIP_FRAMES == 0) state_nxt = RUN;
            else begin
               state_nxt = SKIP;
               skip_nxt  = 16'd0;
            end
         end
         SKIP: if (fs) begin
            skip_nxt = skip_cnt + 16'd1;
            if (skip_nxt == SKIP_N) state_nxt = RUN;
         end
         RUN:     state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // Gating on the next state lets the entry FS itself be emitted
   assign run_nxt  = (state_nxt == RUN);
   assign line_bad = le & ((h_cnt != H_EXP) | phase);
   assign v_cnt_le = (le && v_cnt != CNT_MAX) ? v_cnt + 12'd1 : v_cnt;

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= 1'b0;
         byte_hold <= 8'd0;
         pdata     <= 16'd0;
         de        <= 1'b0;
         vs_out    <= 1'b0;
      end else begin
         if (fs || !href_r) phase <= 1'b0;
         else if (byte_en)  phase <= ~phase;
         if (byte_en && !phase) byte_hold <= data_r;
         de     <= pix & run_nxt;
         vs_out <= vs_n_r & run_nxt;
         if (pix && run_nxt) pdata <= BYTE_ORDER ? {data_r, byte_hold} : {byte_hold, data_r};
      end
   end

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt  <= 12'd0;
         h_meas <= 12'd0;
      end else if (le) begin
         h_meas <= h_cnt;
         h_cnt  <= 12'd0;
      end else if (pix && h_cnt != CNT_MAX) begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

   // A line ending in the FS cycle still counts toward the frame being closed
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         v_cnt     <= 12'd0;
         v_meas    <= 12'd0;
         err_acc   <= 1'b0;
         fs_seen   <= 1'b0;
         size_err  <= 1'b0;
         frame_cnt <= 16'd0;
      end else if (fs) begin
         v_meas   <= v_cnt_le;
         v_cnt    <= 12'd0;
         size_err <= err_acc | line_bad | (fs_seen & (v_cnt_le != V_EXP));
         err_acc  <= 1'b0;
         fs_seen  <= 1'b1;
         if (run_nxt) frame_cnt <= frame_cnt + 16'd1;
      end else begin
         v_cnt <= v_cnt_le;
         if (line_bad) err_acc <= 1'b1;
      end
   end

   assign dvp.pdata_o     = pdata;
   assign dvp.de_o        = de;
   assign dvp.vs_o        = vs_out;
   assign dvp.frame_cnt_o = frame_cnt;
   assign dvp.h_meas_o    = h_meas;
   assign dvp.v_meas_o    = v_meas;
   assign dvp.size_err_o  = size_err;
   assign dvp.dbg_state   = state;
endmodule
